// File: rtl/alu74181_pkg.sv
// Shared constants for the 74181-style ALU: S opcodes, mode select and the
// bit layout of the packed result byte.
package alu74181_pkg;

  localparam logic MODE_LOGIC = 1'b1;
  localparam logic MODE_ARITH = 1'b0;

  // Arithmetic-mode opcodes (named for Cn=1, i.e. no carry-in)
  localparam logic [3:0] S_PASS_A  = 4'b0000;
  localparam logic [3:0] S_MINUS1  = 4'b0011;
  localparam logic [3:0] S_SUB     = 4'b0110;
  localparam logic [3:0] S_ADD     = 4'b1001;
  localparam logic [3:0] S_DOUBLE  = 4'b1100;
  localparam logic [3:0] S_DEC_A   = 4'b1111;

  // Logic-mode opcodes
  localparam logic [3:0] S_NOT_A   = 4'b0000;
  localparam logic [3:0] S_NOR     = 4'b0001;
  localparam logic [3:0] S_ZERO    = 4'b0011;
  localparam logic [3:0] S_NAND    = 4'b0100;
  localparam logic [3:0] S_NOT_B   = 4'b0101;
  localparam logic [3:0] S_XOR     = 4'b0110;
  localparam logic [3:0] S_XNOR    = 4'b1001;
  localparam logic [3:0] S_B       = 4'b1010;
  localparam logic [3:0] S_AND     = 4'b1011;
  localparam logic [3:0] S_ONES    = 4'b1100;
  localparam logic [3:0] S_OR      = 4'b1110;
  localparam logic [3:0] S_A       = 4'b1111;

  // uo_out field layout
  localparam int F_LSB    = 0;
  localparam int F_MSB    = 3;
  localparam int CN4_BIT  = 4;
  localparam int AEQB_BIT = 5;
  localparam int X_BIT    = 6;
  localparam int Y_BIT    = 7;

endpackage

// File: rtl/alu74181_core.sv
// Combinational 74181 function: U/V per-bit terms, 4-bit sum, lookahead
// propagate/generate and the A=B flag.
module alu74181_core
  import alu74181_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cn,
  output logic [3:0] f,
  output logic       cn4,
  output logic       aeqb,
  output logic       x,
  output logic       y
);

  logic [3:0] u;
  logic [3:0] v;
  logic [4:0] sum;
  logic       cin;
  logic       p;
  logic       g;

  assign u   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
  assign v   = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
  assign cin = ~cn;

  // V is always a subset of U, so U+V decomposes cleanly into the P/G lookahead
  assign sum = {1'b0, u} + {1'b0, v} + {4'b0000, cin};

  assign p = &u;
  assign g = v[3] | (u[3] & v[2]) | (u[3] & u[2] & v[1]) | (u[3] & u[2] & u[1] & v[0]);

  assign f    = (m == MODE_LOGIC) ? ~(u ^ v) : sum[3:0];
  assign cn4  = ~(g | (p & cin));
  assign aeqb = (f == 4'b1111);
  assign x    = ~p;
  assign y    = ~g;

endmodule

// File: rtl/calonso88_74181.sv
// Tiny Tapeout top: pin mapping, enable-gated result register with
// asynchronous reset, and constant bidirectional drives.
module calonso88_74181
  import alu74181_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [3:0] f;
  logic       cn4;
  logic       aeqb;
  logic       x;
  logic       y;
  logic [7:0] result;
  logic       unused_uio;

  alu74181_core u_core (
    .a    (ui_in[3:0]),
    .b    (ui_in[7:4]),
    .s    (uio_in[3:0]),
    .m    (uio_in[4]),
    .cn   (uio_in[5]),
    .f    (f),
    .cn4  (cn4),
    .aeqb (aeqb),
    .x    (x),
    .y    (y)
  );

  always_comb begin
    result                = 8'h00;
    result[F_MSB:F_LSB]   = f;
    result[CN4_BIT]       = cn4;
    result[AEQB_BIT]      = aeqb;
    result[X_BIT]         = x;
    result[Y_BIT]         = y;
  end

  // rst_n keeps its historical name but is asserted high
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      uo_out <= 8'h00;
    end else if (ena) begin
      uo_out <= result;
    end
  end

  assign uio_out    = 8'h00;
  assign uio_oe     = 8'h00;
  assign unused_uio = ^uio_in[7:6];

endmodule

// File: tb/tb_calonso88_74181.sv
// Directed and exhaustive checks of the registered 74181 ALU against
// hand-computed values and a function-table reference.
module tb_calonso88_74181;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int errors;
  int checks;

  calonso88_74181 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%02h expected=%02h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s,
                        input logic m, input logic cn);
    ui_in  = {b, a};
    uio_in = {2'b00, cn, m, s};
  endtask

  // drive between edges, then sample 1 time unit after the loading edge
  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s,
                       input logic m, input logic cn);
    @(negedge clk);
    set_in(a, b, s, m, cn);
    @(posedge clk);
    #1;
  endtask

  // Reference built from the published function tables: each arithmetic
  // opcode is "op1 plus op2" with "minus 1" written as "plus 4'hF".
  function automatic logic [7:0] ref_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] s, input logic m, input logic cn);
    logic [3:0] op1, op2, fv;
    logic [4:0] s0, s1;
    logic       p, g, c4, cin;
    cin = ~cn;
    case (s)
      4'h0: begin op1 = a;      op2 = 4'h0;    end
      4'h1: begin op1 = a | b;  op2 = 4'h0;    end
      4'h2: begin op1 = a | ~b; op2 = 4'h0;    end
      4'h3: begin op1 = 4'hF;   op2 = 4'h0;    end
      4'h4: begin op1 = a;      op2 = a & ~b;  end
      4'h5: begin op1 = a | b;  op2 = a & ~b;  end
      4'h6: begin op1 = a | ~b; op2 = a & ~b;  end
      4'h7: begin op1 = 4'hF;   op2 = a & ~b;  end
      4'h8: begin op1 = a;      op2 = a & b;   end
      4'h9: begin op1 = a | b;  op2 = a & b;   end
      4'hA: begin op1 = a | ~b; op2 = a & b;   end
      4'hB: begin op1 = 4'hF;   op2 = a & b;   end
      4'hC: begin op1 = a;      op2 = a;       end
      4'hD: begin op1 = a | b;  op2 = a;       end
      4'hE: begin op1 = a | ~b; op2 = a;       end
      default: begin op1 = 4'hF; op2 = a;      end
    endcase
    s0 = {1'b0, op1} + {1'b0, op2};
    s1 = {1'b0, op1} + {1'b0, op2} + {4'b0000, cin};
    p  = &op1;
    g  = s0[4];
    c4 = s1[4];
    if (m) begin
      case (s)
        4'h0: fv = ~a;
        4'h1: fv = ~(a | b);
        4'h2: fv = ~a & b;
        4'h3: fv = 4'h0;
        4'h4: fv = ~(a & b);
        4'h5: fv = ~b;
        4'h6: fv = a ^ b;
        4'h7: fv = a & ~b;
        4'h8: fv = ~a | b;
        4'h9: fv = ~(a ^ b);
        4'hA: fv = b;
        4'hB: fv = a & b;
        4'hC: fv = 4'hF;
        4'hD: fv = a | ~b;
        4'hE: fv = a | b;
        default: fv = a;
      endcase
    end else begin
      fv = s1[3:0];
    end
    return {~g, ~p, (fv == 4'hF), ~c4, fv};
  endfunction

  initial begin
    errors = 0;
    checks = 0;
    ena    = 1'b1;
    rst_n  = 1'b1;
    set_in(4'h5, 4'h3, 4'b1001, 1'b0, 1'b1);
    #2;
    check("reset_uo_out", uo_out, 8'h00);
    check("reset_uio_out", uio_out, 8'h00);
    check("reset_uio_oe", uio_oe, 8'h00);
    @(posedge clk);
    #1;
    check("reset_held_edge", uo_out, 8'h00);

    // release reset mid-stream: first edge loads current inputs (A=5+B=3)
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("release_first_load", uo_out, 8'hD8);

    // add
    apply(4'h5, 4'h3, 4'b1001, 1'b0, 1'b1);
    check("add_5_3_f", {4'h0, uo_out[3:0]}, 8'h08);
    check("add_5_3_cn4", {7'h0, uo_out[4]}, 8'h01);
    apply(4'hF, 4'h1, 4'b1001, 1'b0, 1'b1);
    check("add_f_1_f", {4'h0, uo_out[3:0]}, 8'h00);
    check("add_f_1_cn4", {7'h0, uo_out[4]}, 8'h00);

    // subtract
    apply(4'h7, 4'h7, 4'b0110, 1'b0, 1'b0);
    check("sub_cn0_f", {4'h0, uo_out[3:0]}, 8'h00);
    check("sub_cn0_cn4", {7'h0, uo_out[4]}, 8'h00);
    check("sub_cn0_aeqb", {7'h0, uo_out[5]}, 8'h00);
    apply(4'h7, 4'h7, 4'b0110, 1'b0, 1'b1);
    check("sub_cn1_f", {4'h0, uo_out[3:0]}, 8'h0F);
    check("sub_cn1_aeqb", {7'h0, uo_out[5]}, 8'h01);

    // logic
    apply(4'hC, 4'hA, 4'b0110, 1'b1, 1'b1);
    check("logic_xor", {4'h0, uo_out[3:0]}, 8'h06);
    apply(4'hC, 4'hA, 4'b1011, 1'b1, 1'b1);
    check("logic_and", {4'h0, uo_out[3:0]}, 8'h08);
    apply(4'hC, 4'hA, 4'b1110, 1'b1, 1'b1);
    check("logic_or", {4'h0, uo_out[3:0]}, 8'h0E);
    apply(4'hC, 4'hA, 4'b0000, 1'b1, 1'b1);
    check("logic_not_a", {4'h0, uo_out[3:0]}, 8'h03);

    // enable hold
    apply(4'h5, 4'h3, 4'b1001, 1'b0, 1'b1);
    check("hold_load", uo_out, 8'hD8);
    @(negedge clk);
    ena = 1'b0;
    set_in(4'hC, 4'hA, 4'b0110, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("hold_ena0", uo_out, 8'hD8);
    end
    @(negedge clk);
    ena = 1'b1;
    @(posedge clk);
    #1;
    check("hold_resume", uo_out, 8'h46);

    // asynchronous reset between edges
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("async_reset", uo_out, 8'h00);
    @(posedge clk);
    #1;
    check("reset_hold_ena1", uo_out, 8'h00);
    check("reset_uio_oe_mid", uio_oe, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;

    // exhaustive sweep of A, B, S, M, Cn
    for (int k = 0; k < 16384; k++) begin
      logic [13:0] vec;
      vec = k[13:0];
      apply(vec[3:0], vec[7:4], vec[11:8], vec[12], vec[13]);
      check($sformatf("exh_%04h", vec), uo_out,
            ref_model(vec[3:0], vec[7:4], vec[11:8], vec[12], vec[13]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
